// File: rtl/weight_bias_loader.sv
// Transmit side of the per-layer neuron weight/bias configuration bus.
// Unpacks an AXI-Stream of (numWeight weights + 1 bias) per neuron into config strobes.
module weight_bias_loader #(
    parameter int dataWidth  = 16,
    parameter int layerNo    = 1,
    parameter int numNeurons = 30,
    parameter int numWeight  = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [dataWidth-1:0]       s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic                       weightValid,
    output logic [dataWidth-1:0]       weightValue,
    output logic [numNeurons-1:0]      biasValid,
    output logic [dataWidth-1:0]       biasValue,
    output logic [2*dataWidth:0]       config_layer_num,
    output logic [2*dataWidth:0]       config_neuron_num,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int CW = 2*dataWidth + 1;
    localparam int WW = (numWeight  > 1) ? $clog2(numWeight)  : 1;
    localparam int NW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
    localparam logic [WW-1:0] W_LAST = WW'(numWeight - 1);
    localparam logic [NW-1:0] N_LAST = NW'(numNeurons - 1);

    typedef enum logic [1:0] {S_IDLE, S_WEIGHT, S_BIAS, S_DONE} state_t;

    state_t        state;
    logic [WW-1:0] widx;
    logic [NW-1:0] neuron;
    logic          beat;

    assign beat = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            widx              <= '0;
            neuron            <= '0;
            s_axis_tready     <= 1'b0;
            weightValid       <= 1'b0;
            weightValue       <= '0;
            biasValid         <= '0;
            biasValue         <= '0;
            config_layer_num  <= '1;
            config_neuron_num <= '1;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
        end else begin
            weightValid <= 1'b0;
            biasValid   <= '0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state             <= S_WEIGHT;
                        widx              <= '0;
                        neuron            <= '0;
                        err               <= 1'b0;
                        s_axis_tready     <= 1'b1;
                        busy              <= 1'b1;
                        config_layer_num  <= CW'(layerNo);
                        config_neuron_num <= '0;
                    end else begin
                        // after an abort, config_* held through the last strobe; release it now
                        config_layer_num  <= '1;
                        config_neuron_num <= '1;
                    end
                end
                S_WEIGHT: begin
                    if (beat) begin
                        weightValid <= 1'b1;
                        weightValue <= s_axis_tdata;
                        if (s_axis_tlast) begin
                            err           <= 1'b1;
                            state         <= S_IDLE;
                            s_axis_tready <= 1'b0;
                            busy          <= 1'b0;
                        end else if (widx == W_LAST) begin
                            widx  <= '0;
                            state <= S_BIAS;
                        end else begin
                            widx <= widx + WW'(1);
                        end
                    end
                end
                S_BIAS: begin
                    if (beat) begin
                        biasValid[neuron] <= 1'b1;
                        biasValue         <= s_axis_tdata;
                        if (neuron == N_LAST) begin
                            if (!s_axis_tlast)
                                err <= 1'b1;
                            state         <= S_DONE;
                            s_axis_tready <= 1'b0;
                            busy          <= 1'b0;
                        end else if (s_axis_tlast) begin
                            err           <= 1'b1;
                            state         <= S_IDLE;
                            s_axis_tready <= 1'b0;
                            busy          <= 1'b0;
                        end else begin
                            neuron            <= neuron + NW'(1);
                            config_neuron_num <= CW'(neuron + NW'(1));
                            state             <= S_WEIGHT;
                        end
                    end
                end
                S_DONE: begin
                    done              <= 1'b1;
                    config_layer_num  <= '1;
                    config_neuron_num <= '1;
                    state             <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
